// File: rtl/alu_mux_ab.sv
// -----------------------------------------------------------------------------
// alu_mux_ab
// Execute-stage datapath slice of the single-cycle RISC-V core.
//   - Mux_B : selects ALU operand B from the I/S immediates, rs2, or zero.
//   - ALU   : add / subtract with zero, negative, carry and overflow flags.
//   - Mux_A : selects the PC increment (constant 4 or the branch offset).
// All datapath outputs are combinational. alu_out_q / cero_q are registered
// copies that give the control unit a clock-aligned view of branch conditions.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset (registers only)
//   doa, dob          register-file read ports (rs1, rs2)
//   imm_ex, imm_sw    sign-extended I-type / S-type immediates
//   i_branch          sign-extended B-type byte offset
//   s_mux_b [1:0]     operand-B select: 00 imm_ex, 01 imm_sw, 10 dob, 11 zero
//   s_mux_a           PC-increment select: 0 -> 4, 1 -> i_branch
//   control_alu       0 = add, 1 = subtract
//   b                 selected operand B
//   alu_out           ALU result
//   cero, neg         result == 0, result sign bit
//   carry             carry out of the MSB (sub: 1 = no borrow)
//   ovf               signed two's-complement overflow
//   op_pc             value added to PC
//   alu_out_q, cero_q registered alu_out / cero
// -----------------------------------------------------------------------------
module alu_mux_ab #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] doa,
  input  logic [WIDTH-1:0] dob,
  input  logic [WIDTH-1:0] imm_ex,
  input  logic [WIDTH-1:0] imm_sw,
  input  logic [WIDTH-1:0] i_branch,
  input  logic [1:0]       s_mux_b,
  input  logic             s_mux_a,
  input  logic             control_alu,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] alu_out,
  output logic             cero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic [WIDTH-1:0] op_pc,
  output logic [WIDTH-1:0] alu_out_q,
  output logic             cero_q
);

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_b_eff;   // b, or ~b when subtracting
  logic [WIDTH:0]   w_sum;     // one extra bit holds the carry out
  logic [WIDTH-1:0] w_res;

  // ---------------------------------------------------------------------------
  // Mux_B
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assigned first so every path drives w_b; no latch is
    // inferred and encoding 11 resolves to a defined zero.
    w_b = '0;
    case (s_mux_b)
      2'b00:   w_b = imm_ex;
      2'b01:   w_b = imm_sw;
      2'b10:   w_b = dob;
      default: w_b = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // ALU: subtract is doa + ~b + 1, so a single adder serves both operations and
  // carry is naturally "no borrow" for subtract.
  // ---------------------------------------------------------------------------
  assign w_b_eff = control_alu ? ~w_b : w_b;
  assign w_sum   = {1'b0, doa} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, control_alu};
  assign w_res   = w_sum[WIDTH-1:0];

  assign b       = w_b;
  assign alu_out = w_res;
  assign cero    = ~|w_res;
  assign neg     = w_res[WIDTH-1];
  assign carry   = w_sum[WIDTH];
  // With the effective (possibly inverted) operand, add and subtract share one
  // rule: operand signs equal and the result sign differs from doa.
  assign ovf     = (doa[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                   (w_res[WIDTH-1] != doa[WIDTH-1]);

  // ---------------------------------------------------------------------------
  // Mux_A
  // ---------------------------------------------------------------------------
  assign op_pc = s_mux_a ? i_branch : PC_STEP;

  // ---------------------------------------------------------------------------
  // Clock-aligned copies of the result and zero flag
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] r_alu_out;
  logic             r_cero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_out <= '0;
      r_cero    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      r_alu_out <= w_res;
      r_cero    <= ~|w_res;
    end
  end

  assign alu_out_q = r_alu_out;
  assign cero_q    = r_cero;

endmodule

// File: tb/tb_alu_mux_ab.sv
// -----------------------------------------------------------------------------
// tb_alu_mux_ab
// Self-checking bench for alu_mux_ab. Directed scenarios followed by random
// operations; expected values come from an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_alu_mux_ab;

  logic        clk;
  logic        rst_n;
  logic [31:0] doa, dob, imm_ex, imm_sw, i_branch;
  logic [1:0]  s_mux_b;
  logic        s_mux_a;
  logic        control_alu;
  logic [31:0] b, alu_out, op_pc, alu_out_q;
  logic        cero, neg, carry, ovf, cero_q;

  int n_checks = 0;
  int n_errors = 0;

  alu_mux_ab #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .doa        (doa),
    .dob        (dob),
    .imm_ex     (imm_ex),
    .imm_sw     (imm_sw),
    .i_branch   (i_branch),
    .s_mux_b    (s_mux_b),
    .s_mux_a    (s_mux_a),
    .control_alu(control_alu),
    .b          (b),
    .alu_out    (alu_out),
    .cero       (cero),
    .neg        (neg),
    .carry      (carry),
    .ovf        (ovf),
    .op_pc      (op_pc),
    .alu_out_q  (alu_out_q),
    .cero_q     (cero_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Reference model: plain integer arithmetic on 64-bit values.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] b;
    logic [31:0] res;
    logic        z, n, c, v;
    logic [31:0] pc;
  } exp_t;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] rs2,
                                 input logic [31:0] ie, input logic [31:0] is,
                                 input logic [31:0] br, input logic [1:0] sb,
                                 input logic sa, input logic sub);
    exp_t   e;
    longint ua, ub, sa_v, sb_v, sr, ur;
    if      (sb == 2'd0) e.b = ie;
    else if (sb == 2'd1) e.b = is;
    else if (sb == 2'd2) e.b = rs2;
    else                 e.b = 32'd0;
    ua   = longint'(a);
    ub   = longint'(e.b);
    sa_v = longint'($signed(a));
    sb_v = longint'($signed(e.b));
    if (sub) begin
      ur  = ua - ub;
      e.c = (ua >= ub);
      sr  = sa_v - sb_v;
    end else begin
      ur  = ua + ub;
      e.c = (ur >= 64'sd4294967296);
      sr  = sa_v + sb_v;
    end
    e.res = ur[31:0];
    e.z   = (e.res == 32'd0);
    e.n   = e.res[31];
    e.v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    e.pc  = sa ? br : 32'd4;
    return e;
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] rs2,
                       input logic [31:0] ie, input logic [31:0] is,
                       input logic [31:0] br, input logic [1:0] sb,
                       input logic sa, input logic sub);
    doa = a; dob = rs2; imm_ex = ie; imm_sw = is; i_branch = br;
    s_mux_b = sb; s_mux_a = sa; control_alu = sub;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive(32'd7, 32'd0, 32'd9, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (alu_out_q !== 32'd0) begin
      n_errors++; $display("FAIL reset_alu_out_q: got %h expected %h", alu_out_q, 32'd0);
    end
    n_checks++;
    if (cero_q !== 1'b0) begin
      n_errors++; $display("FAIL reset_cero_q: got %b expected 0", cero_q);
    end
    n_checks++;
    if (alu_out !== 32'd16) begin
      n_errors++; $display("FAIL reset_comb_alu_out: got %h expected %h", alu_out, 32'd16);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_imm();
    @(negedge clk);
    drive(32'd5, 32'd0, 32'hFFFF_FFFD, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0);
    #1;
    n_checks++;
    if ({b, alu_out, carry, cero, ovf} !== {32'hFFFF_FFFD, 32'd2, 1'b1, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL add_imm: got b=%h res=%h c=%b z=%b v=%b expected b=fffffffd res=2 c=1 z=0 v=0",
               b, alu_out, carry, cero, ovf);
    end
  endtask

  task automatic test_bne_equal();
    @(negedge clk);
    drive(32'h1234_5678, 32'h1234_5678, 32'd0, 32'd0, 32'd0, 2'b10, 1'b0, 1'b1);
    #1;
    n_checks++;
    if ({alu_out, cero, carry} !== {32'd0, 1'b1, 1'b1}) begin
      n_errors++;
      $display("FAIL bne_equal: got res=%h z=%b c=%b expected res=0 z=1 c=1", alu_out, cero, carry);
    end
    @(posedge clk); #1;
    n_checks++;
    if (cero_q !== 1'b1) begin
      n_errors++; $display("FAIL bne_cero_q: got %b expected 1", cero_q);
    end
  endtask

  task automatic test_overflow_borrow();
    @(negedge clk);
    drive(32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0, 2'b10, 1'b0, 1'b0);
    #1;
    n_checks++;
    if ({alu_out, ovf, neg} !== {32'h8000_0000, 1'b1, 1'b1}) begin
      n_errors++;
      $display("FAIL add_ovf: got res=%h v=%b n=%b expected res=80000000 v=1 n=1", alu_out, ovf, neg);
    end
    @(negedge clk);
    drive(32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 2'b10, 1'b0, 1'b1);
    #1;
    n_checks++;
    if ({alu_out, carry, neg, ovf} !== {32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0}) begin
      n_errors++;
      $display("FAIL sub_borrow: got res=%h c=%b n=%b v=%b expected res=ffffffff c=0 n=1 v=0",
               alu_out, carry, neg, ovf);
    end
    // Subtract overflow: most negative minus one.
    @(negedge clk);
    drive(32'h8000_0000, 32'd1, 32'd0, 32'd0, 32'd0, 2'b10, 1'b0, 1'b1);
    #1;
    n_checks++;
    if ({alu_out, ovf, carry} !== {32'h7FFF_FFFF, 1'b1, 1'b1}) begin
      n_errors++;
      $display("FAIL sub_ovf: got res=%h v=%b c=%b expected res=7fffffff v=1 c=1", alu_out, ovf, carry);
    end
  endtask

  task automatic test_store_addr();
    @(negedge clk);
    drive(32'h100, 32'hDEAD_BEEF, 32'h55, 32'd8, 32'd0, 2'b01, 1'b0, 1'b0);
    #1;
    n_checks++;
    if ({b, alu_out} !== {32'd8, 32'h108}) begin
      n_errors++; $display("FAIL store_addr: got b=%h res=%h expected b=8 res=108", b, alu_out);
    end
    s_mux_b = 2'b11;
    #1;
    n_checks++;
    if ({b, alu_out} !== {32'd0, 32'h100}) begin
      n_errors++; $display("FAIL mux_b_zero: got b=%h res=%h expected b=0 res=100", b, alu_out);
    end
  endtask

  task automatic test_pc_select();
    @(negedge clk);
    drive(32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFF0, 2'b00, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (op_pc !== 32'd4) begin
      n_errors++; $display("FAIL pc_step: got %h expected %h", op_pc, 32'd4);
    end
    s_mux_a = 1'b1;
    #1;
    n_checks++;
    if (op_pc !== 32'hFFFF_FFF0) begin
      n_errors++; $display("FAIL pc_branch: got %h expected %h", op_pc, 32'hFFFF_FFF0);
    end
    s_mux_a = 1'b0;
    #1;
    n_checks++;
    if (op_pc !== 32'd4) begin
      n_errors++; $display("FAIL pc_toggle_back: got %h expected %h", op_pc, 32'd4);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    drive(32'h100, 32'd0, 32'd0, 32'd8, 32'd0, 2'b01, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_checks++;
    if (alu_out_q !== 32'h108) begin
      n_errors++; $display("FAIL areset_setup: got %h expected %h", alu_out_q, 32'h108);
    end
    #2;                    // between edges
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({alu_out_q, cero_q} !== {32'd0, 1'b0}) begin
      n_errors++; $display("FAIL areset_immediate: got q=%h zq=%b expected q=0 zq=0", alu_out_q, cero_q);
    end
    n_checks++;
    if (alu_out !== 32'h108) begin
      n_errors++; $display("FAIL areset_comb: got %h expected %h", alu_out, 32'h108);
    end
    @(posedge clk); #1;
    n_checks++;
    if (alu_out_q !== 32'd0) begin
      n_errors++; $display("FAIL areset_hold: got %h expected 0", alu_out_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (alu_out_q !== 32'd0) begin
      n_errors++; $display("FAIL areset_before_edge: got %h expected 0", alu_out_q);
    end
    @(posedge clk); #1;
    n_checks++;
    if (alu_out_q !== 32'h108) begin
      n_errors++; $display("FAIL areset_release: got %h expected %h", alu_out_q, 32'h108);
    end
  endtask

  // Random operations, one per cycle; the registered outputs are checked one
  // edge after each operation is applied.
  task automatic test_back_to_back();
    exp_t e;
    logic [31:0] a, r2, ie, is, br;
    logic [1:0]  sb;
    logic        sa, sub;
    for (int i = 0; i < 200; i++) begin
      a  = $urandom();
      r2 = (i % 8 == 0) ? a : $urandom();   // force some zero results
      ie = $urandom();
      is = $urandom();
      br = $urandom();
      sb = 2'($urandom_range(0, 3));
      sa = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      if (i % 8 == 0) begin sb = 2'b10; sub = 1'b1; end
      if (i % 16 == 4) a = 32'h7FFF_FFFF;
      @(negedge clk);
      drive(a, r2, ie, is, br, sb, sa, sub);
      e = model(a, r2, ie, is, br, sb, sa, sub);
      #1;
      n_checks++;
      if ({b, alu_out, cero, neg, carry, ovf, op_pc} !==
          {e.b, e.res, e.z, e.n, e.c, e.v, e.pc}) begin
        n_errors++;
        $display("FAIL rand_comb[%0d]: got b=%h r=%h z%b n%b c%b v%b pc=%h expected b=%h r=%h z%b n%b c%b v%b pc=%h",
                 i, b, alu_out, cero, neg, carry, ovf, op_pc,
                 e.b, e.res, e.z, e.n, e.c, e.v, e.pc);
      end
      @(posedge clk); #1;
      n_checks++;
      if ({alu_out_q, cero_q} !== {e.res, e.z}) begin
        n_errors++;
        $display("FAIL rand_reg[%0d]: got q=%h zq=%b expected q=%h zq=%b",
                 i, alu_out_q, cero_q, e.res, e.z);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_imm();
    test_bne_equal();
    test_overflow_borrow();
    test_store_addr();
    test_pc_select();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_mux_ab.md
# alu_mux_ab

Execute-stage datapath slice of the single-cycle RISC-V core. It contains three parts:
- the operand-B selector (Mux_B);
- the add/sub ALU with a zero flag and extra status flags;
- the PC-increment selector (Mux_A), which feeds the PC adder.

All datapath results are combinational. Registered copies of the ALU result and the zero flag give the control unit a clock-aligned view of branch conditions.

## Interface
Parameters:
- WIDTH, 32, datapath width. All data ports below use WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- doa  in  32  register-file port A (rs1); ALU operand A.
- dob  in  32  register-file port B (rs2).
- imm_ex  in  32  sign-extended I-type immediate.
- imm_sw  in  32  sign-extended S-type (store) immediate.
- i_branch  in  32  sign-extended B-type byte offset.
- s_mux_b  in  2  operand-B select.
- s_mux_a  in  1  PC-increment select.
- control_alu  in  1  ALU operation: 0 = add, 1 = subtract.
- b  out  32  selected operand B (also exported for debug).
- alu_out  out  32  ALU result, combinational.
- cero  out  1  1 when alu_out == 0, combinational.
- neg  out  1  alu_out[31].
- carry  out  1  add: carry out of bit 31. Sub: 1 = no borrow (doa >= b, unsigned).
- ovf  out  1  signed two's-complement overflow.
- op_pc  out  32  value added to PC by the PC adder.
- alu_out_q  out  32  alu_out registered.
- cero_q  out  1  cero registered.

## Operation
- Mux_B select, s_mux_b:
  - 00 → imm_ex
  - 01 → imm_sw
  - 10 → dob
  - 11 → 32'h0000_0000 (defined, never X)
- ALU:
  - control_alu = 0: alu_out = doa + b, modulo 2^32.
  - control_alu = 1: alu_out = doa + ~b + 1, modulo 2^32.
- carry is bit 32 of the 33-bit unsigned sum in both cases.
- ovf for add: operands have the same sign and the result sign differs.
- ovf for sub: operands have different signs and the result sign differs from doa.
- cero = ~|alu_out. neg = alu_out[31].
- Mux_A select, s_mux_a:
  - 0 → op_pc = 32'd4
  - 1 → op_pc = i_branch, passed through unmodified.
- BNE handling belongs to the control unit. It drives s_mux_a from cero after a subtract; this block does no branch decision.
- No X propagation from the selects: every encoding of s_mux_b, s_mux_a and control_alu yields a defined output.

## Timing
- b, alu_out, cero, neg, carry, ovf and op_pc are purely combinational. They are valid in the same cycle as their inputs and are unaffected by rst_n.
- alu_out_q and cero_q capture alu_out and cero on every rising clk edge. Latency is 1 cycle; there is no enable.
- rst_n low forces alu_out_q = 0 and cero_q = 0 immediately, without waiting for clk. They stay there while rst_n is low.
- After rst_n rises, the first capture happens at the next rising clk edge.
- If rst_n deasserts coincident with a clk edge, the registers hold 0 for that edge.
- Reset mid-operation discards the registered values only; the combinational outputs keep tracking their inputs.
- No handshake; one operation per cycle.

## Test plan
- Add, imm_ex: doa = 5, imm_ex = 0xFFFF_FFFD (-3), s_mux_b = 00, control_alu = 0 → b = 0xFFFF_FFFD, alu_out = 2, carry = 1, cero = 0, ovf = 0.
- BNE, equal operands: doa = dob = 0x1234_5678, s_mux_b = 10, control_alu = 1 → alu_out = 0, cero = 1, carry = 1. Next edge: cero_q = 1.
- Overflow and borrow:
  - doa = 0x7FFF_FFFF + b = 1 (add) → alu_out = 0x8000_0000, ovf = 1, neg = 1.
  - doa = 0 − b = 1 (sub) → alu_out = 0xFFFF_FFFF, carry = 0, neg = 1.
- Store address: doa = 0x100, imm_sw = 8, s_mux_b = 01, add → alu_out = 0x108. With s_mux_b = 11 → b = 0, alu_out = 0x100.
- PC select:
  - s_mux_a = 0 → op_pc = 4.
  - s_mux_a = 1, i_branch = 0xFFFF_FFF0 → op_pc = 0xFFFF_FFF0.
  - Toggling s_mux_a changes op_pc in the same cycle.
- Async reset: with alu_out_q = 0x108, drive rst_n low between clk edges → alu_out_q = 0 and cero_q = 0 immediately. Combinational alu_out stays 0x108. After release, alu_out_q = 0x108 at the first rising edge.
